hazard_ctrl_pipe: RTL
=====================

# hazard_ctrl_pipe

Pipeline-side counterpart of the ID-stage control decoder. It consumes the decoded control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, Branch) and carries it through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and drives the decoder's active-low NoOp input, plus PC/IF-ID write enables and the IF/ID flush. It also generates EX-stage forwarding selects and keeps a saturating bubble counter.

## Interface
- CNT_W, 16, width of bubble counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_RegWrite_i, id_MemtoReg_i, id_MemRead_i, id_MemWrite_i, id_ALUSrc_i, id_Branch_i  in  1 each  decoded control from ID
- id_ALUOp_i  in  2  decoded ALUOp
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register fields of instruction in ID
- branch_taken_i  in  1  ID-stage branch resolved taken
- mem_stall_i  in  1  data memory busy; freezes whole pipe
- NoOp_o  out  1  to decoder; 0 = force bubble, 1 = normal decode
- PCWrite_o, IFIDWrite_o  out  1 each  PC / IF-ID register write enables
- Flush_o  out  1  clear IF/ID
- ex_ALUOp_o  out  2; ex_ALUSrc_o  out  1  ID/EX stage controls
- mem_MemRead_o, mem_MemWrite_o  out  1 each  EX/MEM stage controls
- wb_RegWrite_o, wb_MemtoReg_o  out  1 each  MEM/WB stage controls
- ex_rd_o, mem_rd_o, wb_rd_o  out  5 each  destination register per stage
- ForwardA_o, ForwardB_o  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted, saturating

## Operation
- ID/EX holds all seven controls plus rs1, rs2, rd. EX/MEM holds RegWrite, MemtoReg, MemRead, MemWrite and rd. MEM/WB holds RegWrite, MemtoReg and rd.
- load_use = ex_MemRead & (ex_rd != 0) & ((ex_rd == id_rs1_i) | (ex_rd == id_rs2_i)).
- Mode priority, evaluated combinationally each cycle:
  - FREEZE (mem_stall_i=1): all three stage registers hold. PCWrite_o=0, IFIDWrite_o=0, NoOp_o=1, Flush_o=0. The counter holds.
  - BUBBLE (load_use=1, no freeze): NoOp_o=0, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0. ID/EX loads all-zero controls and rd=0, independent of the id_* inputs. EX/MEM and MEM/WB advance. bubble_cnt increments unless it is all-ones.
  - RUN: NoOp_o=1, PCWrite_o=1, IFIDWrite_o=1, Flush_o=branch_taken_i. All registers advance.
- A load-use hazard seen during FREEZE is deferred. The bubble is inserted on the first non-freeze cycle, counted once.
- Forwarding (per operand X in {A: ex_rs1, B: ex_rs2}):
  - 10 if mem_RegWrite & mem_rd≠0 & mem_rd==ex_rsX;
  - else 01 if wb_RegWrite & wb_rd≠0 & wb_rd==ex_rsX;
  - else 00.
  - The EX/MEM match wins when both stages match.
- Register x0 never causes a hazard or a forward.

## Timing
- All stage registers and the counter are rising-edge, cleared asynchronously while rst_i=0. After reset every stage is a bubble, so the outputs are:
  - all stage controls = 0;
  - all rd outputs = 0;
  - ForwardA_o = ForwardB_o = 00;
  - bubble_cnt_o = 0;
  - NoOp_o = 1, PCWrite_o = 1, IFIDWrite_o = 1, Flush_o = 0.
- NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o and Forward* are combinational from the current stage registers and inputs. They are valid in the same cycle, with no registered latency.
- Stage latency: an ID-stage bundle appears on ex_* 1 cycle later, mem_* after 2, wb_* after 3, each stretched by freeze cycles.
- A load-use hazard yields exactly one bubble cycle. The dependent instruction stays in ID and proceeds on the next cycle, because ex_MemRead is then 0.
- Reset asserted mid-operation clears all in-flight controls immediately. No stale RegWrite or MemWrite may appear after release.
- The counter saturates at 2^CNT_W−1 and never wraps.

## Test plan
- Reset: assert rst_i=0 mid-stream with wb_RegWrite=1 → wb_RegWrite_o drops to 0 without a clock edge; after release, NoOp_o=1, PCWrite_o=1, bubble_cnt_o=0.
- Load-use: lw x5 enters ID/EX (ex_MemRead=1, ex_rd=5), then id_rs2_i=5 → NoOp_o=0, PCWrite_o=0, IFIDWrite_o=0 for exactly 1 cycle. Next cycle ex_* = all 0, then normal; bubble_cnt_o=1. Repeat with ex_rd=0 → no stall.
- Forwarding: mem_rd=3 and wb_rd=3 with both RegWrite=1, ex_rs1=3 → ForwardA_o=10. Clear mem_RegWrite → 01. Set ex_rs2=0 with wb_rd=0 → ForwardB_o=00.
- Freeze: mem_stall_i=1 for 3 cycles with a load-use pending → all stage outputs constant, NoOp_o=1, counter constant. On release, one bubble is inserted and bubble_cnt_o increments by 1.
- Branch flush: branch_taken_i=1 with no hazard → Flush_o=1. With load_use=1 in the same cycle → Flush_o=0, bubble inserted.
- Saturation: with CNT_W=4, force 20 load-use bubbles → bubble_cnt_o stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_pipe.sv
// Pipeline control carrier for ID/EX, EX/MEM and MEM/WB with load-use stall,
// branch flush, EX-stage forwarding selects and a saturating bubble counter.
module hazard_ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_RegWrite_i,
  input  logic             id_MemtoReg_i,
  input  logic             id_MemRead_i,
  input  logic             id_MemWrite_i,
  input  logic             id_ALUSrc_i,
  input  logic             id_Branch_i,
  input  logic [1:0]       id_ALUOp_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             NoOp_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             Flush_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic             ex_ALUSrc_o,
  output logic             mem_MemRead_o,
  output logic             mem_MemWrite_o,
  output logic             wb_RegWrite_o,
  output logic             wb_MemtoReg_o,
  output logic [4:0]       ex_rd_o,
  output logic [4:0]       mem_rd_o,
  output logic [4:0]       wb_rd_o,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic             r_ex_RegWrite, r_ex_MemtoReg, r_ex_MemRead, r_ex_MemWrite;
  logic             r_ex_ALUSrc, r_ex_Branch;
  logic [1:0]       r_ex_ALUOp;
  logic [4:0]       r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic             r_mem_RegWrite, r_mem_MemtoReg, r_mem_MemRead, r_mem_MemWrite;
  logic [4:0]       r_mem_rd;
  logic             r_wb_RegWrite, r_wb_MemtoReg;
  logic [4:0]       r_wb_rd;
  logic [CNT_W-1:0] r_cnt;

  logic w_freeze, w_load_use, w_bubble;
  // Branch is carried for downstream consumers but has no output port here.
  logic w_unused_branch;

  assign w_unused_branch = r_ex_Branch;
  assign w_freeze   = mem_stall_i;
  assign w_load_use = r_ex_MemRead & (r_ex_rd != 5'd0) &
                      ((r_ex_rd == id_rs1_i) | (r_ex_rd == id_rs2_i));
  // A hazard under freeze stays pending because ID/EX and ID both hold.
  assign w_bubble   = w_load_use & ~w_freeze;

  assign NoOp_o      = ~w_bubble;
  assign PCWrite_o   = ~w_freeze & ~w_load_use;
  assign IFIDWrite_o = ~w_freeze & ~w_load_use;
  assign Flush_o     = ~w_freeze & ~w_load_use & branch_taken_i;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs))
      sel = 2'b10;
    else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardA_o = fwd_sel(r_ex_rs1, r_mem_RegWrite, r_mem_rd, r_wb_RegWrite, r_wb_rd);
  assign ForwardB_o = fwd_sel(r_ex_rs2, r_mem_RegWrite, r_mem_rd, r_wb_RegWrite, r_wb_rd);

  // ID/EX stage
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex_RegWrite <= 1'b0;
      r_ex_MemtoReg <= 1'b0;
      r_ex_MemRead  <= 1'b0;
      r_ex_MemWrite <= 1'b0;
      r_ex_ALUSrc   <= 1'b0;
      r_ex_Branch   <= 1'b0;
      r_ex_ALUOp    <= 2'b00;
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_ex_rd       <= 5'd0;
    end else if (!w_freeze) begin
      if (w_bubble) begin
        r_ex_RegWrite <= 1'b0;
        r_ex_MemtoReg <= 1'b0;
        r_ex_MemRead  <= 1'b0;
        r_ex_MemWrite <= 1'b0;
        r_ex_ALUSrc   <= 1'b0;
        r_ex_Branch   <= 1'b0;
        r_ex_ALUOp    <= 2'b00;
        r_ex_rs1      <= 5'd0;
        r_ex_rs2      <= 5'd0;
        r_ex_rd       <= 5'd0;
      end else begin
        r_ex_RegWrite <= id_RegWrite_i;
        r_ex_MemtoReg <= id_MemtoReg_i;
        r_ex_MemRead  <= id_MemRead_i;
        r_ex_MemWrite <= id_MemWrite_i;
        r_ex_ALUSrc   <= id_ALUSrc_i;
        r_ex_Branch   <= id_Branch_i;
        r_ex_ALUOp    <= id_ALUOp_i;
        r_ex_rs1      <= id_rs1_i;
        r_ex_rs2      <= id_rs2_i;
        r_ex_rd       <= id_rd_i;
      end
    end
  end

  // EX/MEM and MEM/WB stages
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_RegWrite <= 1'b0;
      r_mem_MemtoReg <= 1'b0;
      r_mem_MemRead  <= 1'b0;
      r_mem_MemWrite <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_wb_RegWrite  <= 1'b0;
      r_wb_MemtoReg  <= 1'b0;
      r_wb_rd        <= 5'd0;
    end else if (!w_freeze) begin
      r_mem_RegWrite <= r_ex_RegWrite;
      r_mem_MemtoReg <= r_ex_MemtoReg;
      r_mem_MemRead  <= r_ex_MemRead;
      r_mem_MemWrite <= r_ex_MemWrite;
      r_mem_rd       <= r_ex_rd;
      r_wb_RegWrite  <= r_mem_RegWrite;
      r_wb_MemtoReg  <= r_mem_MemtoReg;
      r_wb_rd        <= r_mem_rd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_cnt <= '0;
    else if (w_bubble && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign ex_ALUOp_o     = r_ex_ALUOp;
  assign ex_ALUSrc_o    = r_ex_ALUSrc;
  assign ex_rd_o        = r_ex_rd;
  assign mem_MemRead_o  = r_mem_MemRead;
  assign mem_MemWrite_o = r_mem_MemWrite;
  assign mem_rd_o       = r_mem_rd;
  assign wb_RegWrite_o  = r_wb_RegWrite;
  assign wb_MemtoReg_o  = r_wb_MemtoReg;
  assign wb_rd_o        = r_wb_rd;
  assign bubble_cnt_o   = r_cnt;

endmodule
